cdm_err_sweep: RTL and testbench

- Self-timed exhaustive sweep and error-metric engine for the W x W carry-disregard approximate multipliers.
- Sits directly upstream and downstream of the multiplier under test:
  - drives its A/B operands;
  - consumes its combinational product R;
  - compares R against the exact product;
  - accumulates error statistics over all 2^(2W) operand pairs.
- Replaces file-dump post-processing with on-chip ED/error-rate/worst-case metrics.

---
 rtl/cdm_err_sweep.sv | 104 ++++++++++
 tb/tb_cdm_err_sweep.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cdm_err_sweep.sv
// rtl/cdm_err_sweep.sv - exhaustive operand sweep and error metrics for a WxW approximate multiplier
// Drives every {A,B} pair once and accumulates ED sum, error count and worst-case pair.
module cdm_err_sweep #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  input  logic [2*W-1:0]   r_in,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     err_count,
  output logic [4*W-1:0]   ed_sum,
  output logic [2*W-1:0]   max_ed,
  output logic [W-1:0]     worst_a,
  output logic [W-1:0]     worst_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [2*W-1:0] CNT_LAST = '1;

  state_t         state, state_nxt;
  logic           launch;
  logic [2*W-1:0] cnt;
  logic [2*W-1:0] exact;
  logic [2*W-1:0] ed;
  logic [2*W-1:0] ed_q;
  logic           ne_q;
  logic [W-1:0]   wa_q;
  logic [W-1:0]   wb_q;
  logic           v_q;

  // A is the outer loop, so it occupies the upper half of the counter.
  assign {a_out, b_out} = cnt;
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  assign exact = {{W{1'b0}}, a_out} * {{W{1'b0}}, b_out};
  assign ed    = (exact >= r_in) ? (exact - r_in) : (r_in - exact);

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN:     if (cnt == CNT_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      v_q       <= 1'b0;
      ed_q      <= '0;
      ne_q      <= 1'b0;
      wa_q      <= '0;
      wb_q      <= '0;
      err_count <= '0;
      ed_sum    <= '0;
      max_ed    <= '0;
      worst_a   <= '0;
      worst_b   <= '0;
    end else begin
      state <= state_nxt;
      v_q   <= (state == RUN);
      if (state == RUN) begin
        cnt  <= cnt + 1'b1;
        ed_q <= ed;
        ne_q <= (ed != '0);
        wa_q <= a_out;
        wb_q <= b_out;
      end
      if (launch) begin
        cnt       <= '0;
        err_count <= '0;
        ed_sum    <= '0;
        max_ed    <= '0;
        worst_a   <= '0;
        worst_b   <= '0;
      end else if (v_q) begin
        err_count <= err_count + {{(2*W){1'b0}}, ne_q};
        ed_sum    <= ed_sum + {{(2*W){1'b0}}, ed_q};
        // Strict compare keeps the earliest pair on ties.
        if (ed_q > max_ed) begin
          max_ed  <= ed_q;
          worst_a <= wa_q;
          worst_b <= wb_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdm_err_sweep.sv
// tb/tb_cdm_err_sweep.sv - bench for cdm_err_sweep at W=2 (stub products) and W=8 (carry-less multiplier)
module tb_cdm_err_sweep;

  typedef struct {
    int mode;
    int ec;
    int es;
    int me;
    int wa;
    int wb;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // W=2 instance with selectable product stub
  logic       rst2, start2;
  logic [1:0] a2, b2;
  logic [3:0] r2, p2;
  logic       busy2, done2;
  logic [4:0] ec2;
  logic [7:0] es2;
  logic [3:0] me2;
  logic [1:0] wa2, wb2;
  int         mode;

  assign p2 = {2'b00, a2} * {2'b00, b2};
  always_comb begin
    r2 = p2;
    case (mode)
      1:       r2 = 4'h0;
      2:       r2 = p2 + 4'h1;
      3:       r2 = 4'hF;
      default: r2 = p2;
    endcase
  end

  cdm_err_sweep #(.W(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .a_out(a2), .b_out(b2), .r_in(r2),
    .busy(busy2), .done(done2), .err_count(ec2), .ed_sum(es2), .max_ed(me2),
    .worst_a(wa2), .worst_b(wb2)
  );

  // W=8 instance driven by a carry-disregard (carry-less) multiplier
  logic        rst8, start8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        busy8, done8;
  logic [16:0] ec8;
  logic [31:0] es8;
  logic [15:0] me8;
  logic [7:0]  wa8, wb8;

  function automatic logic [15:0] cl_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) acc = acc ^ ({8'h00, a} << i);
    return acc;
  endfunction

  assign r8 = cl_mul(a8, b8);

  cdm_err_sweep #(.W(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a_out(a8), .b_out(b8), .r_in(r8),
    .busy(busy8), .done(done8), .err_count(ec8), .ed_sum(es8), .max_ed(me8),
    .worst_a(wa8), .worst_b(wb8)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  vec_t exp_q[$];
  int   op_q[$];

  task automatic chk_idle2(input string tag);
    chk({tag, "_busy"}, busy2, 0);
    chk({tag, "_done"}, done2, 0);
    chk({tag, "_ec"}, ec2, 0);
    chk({tag, "_es"}, es2, 0);
    chk({tag, "_me"}, me2, 0);
    chk({tag, "_wa"}, wa2, 0);
    chk({tag, "_wb"}, wb2, 0);
    chk({tag, "_ab"}, {a2, b2}, 0);
  endtask

  task automatic run2(input vec_t v, input bit chk_ops);
    int   cyc;
    vec_t e;
    exp_q.push_back(v);
    if (chk_ops) for (int i = 0; i < 16; i++) op_q.push_back(i);
    mode = v.mode;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    chk("start_done_low", done2, 0);
    chk("start_ec_clear", ec2, 0);
    cyc = 0;
    while (busy2 && cyc < 100) begin
      if (op_q.size() > 0) chk("operand", {a2, b2}, op_q.pop_front());
      cyc++;
      @(negedge clk);
    end
    chk("busy_cycles", cyc, 17);
    chk("op_queue_left", op_q.size(), 0);
    op_q.delete();
    chk("done_high", done2, 1);
    chk("done_ab_zero", {a2, b2}, 0);
    e = exp_q.pop_front();
    chk("err_count", ec2, e.ec);
    chk("ed_sum", es2, e.es);
    chk("max_ed", me2, e.me);
    chk("worst_a", wa2, e.wa);
    chk("worst_b", wb2, e.wb);
  endtask

  vec_t tbl[4];

  initial begin
    rst2 = 1'b1; start2 = 1'b0; mode = 0;
    rst8 = 1'b1; start8 = 1'b0;
    tbl[0] = '{mode: 0, ec: 0,  es: 0,   me: 0,  wa: 0, wb: 0};
    tbl[1] = '{mode: 1, ec: 9,  es: 36,  me: 9,  wa: 3, wb: 3};
    tbl[2] = '{mode: 2, ec: 16, es: 16,  me: 1,  wa: 0, wb: 0};
    tbl[3] = '{mode: 3, ec: 16, es: 204, me: 15, wa: 0, wb: 0};
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    rst8 = 1'b0;
    fork
      begin : w2_path
        chk_idle2("reset");
        for (int i = 0; i < 4; i++) run2(tbl[i], i == 0);

        // Reset mid-sweep with start held high throughout RUN
        mode = 0;
        @(negedge clk) start2 = 1'b1;
        repeat (5) @(negedge clk);
        chk("hold_start_busy", busy2, 1);
        chk("hold_start_cnt", {a2, b2}, 4);
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0; start2 = 1'b0;
        chk_idle2("midreset");
        @(negedge clk);
        chk_idle2("after_reset");
        run2(tbl[0], 1'b1);
      end
      begin : w8_path
        longint ref_ec, ref_es, ref_me, ref_wa, ref_wb, ex, ap, d;
        int cyc;
        ref_ec = 0; ref_es = 0; ref_me = 0; ref_wa = 0; ref_wb = 0;
        for (int a = 0; a < 256; a++)
          for (int b = 0; b < 256; b++) begin
            ex = longint'(a) * longint'(b);
            ap = longint'(cl_mul(8'(a), 8'(b)));
            d  = (ex > ap) ? ex - ap : ap - ex;
            if (d != 0) ref_ec++;
            ref_es += d;
            if (d > ref_me) begin ref_me = d; ref_wa = a; ref_wb = b; end
          end
        @(negedge clk) start8 = 1'b1;
        @(negedge clk) start8 = 1'b0;
        cyc = 0;
        while (busy8 && cyc < 70000) begin
          cyc++;
          @(negedge clk);
        end
        chk("w8_busy_cycles", cyc, 65537);
        chk("w8_done", done8, 1);
        chk("w8_err_count", ec8, ref_ec);
        chk("w8_ed_sum", es8, ref_es);
        chk("w8_max_ed", me8, ref_me);
        chk("w8_worst_a", wa8, ref_wa);
        chk("w8_worst_b", wb8, ref_wb);
        chk("w8_done_ab", {a8, b8}, 0);
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
